muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Sequences the multi-cycle multiplier and divider for the multicycle MIPS core.
//  The control unit issues a one-cycle start request. This block then:
//   - launches the selected unit,
//   - waits for its stop flag, bounded by a watchdog,
//   - commits HI/LO, or raises a divide-by-zero or timeout exception.
//  It sits between the control unit and the mult/div units, and drives the HI/LO register load and source muxes.
// PARAMETERS
//  MAX_CYCLES  64  wait cycles allowed after launch before timeout_exc (2..127)
//  CNT_W       7   watchdog counter width; must satisfy 2**CNT_W > MAX_CYCLES
// PORTS
//  clk           in   1   system clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  start_mult    in   1   1-cycle request: MULT (from control unit)
//  start_div     in   1   1-cycle request: DIV (from control unit)
//  divisor       in   32  B register value, sampled with start_div
//  mult_stop     in   1   multiplier finished (level, unit-held)
//  div_stop      in   1   divider finished (level, unit-held)
//  div_zero      in   1   divider reports zero divisor
//  mult_control  out  1   start pulse to multiplier
//  div_control   out  1   start pulse to divider
//  HiLo_load     out  1   write enable for HI and LO
//  sel_mux_hi    out  1   HI source: 0 = mult, 1 = div
//  sel_mux_lo    out  1   LO source: 0 = mult, 1 = div
//  busy          out  1   high in every state except IDLE
//  done          out  1   1-cycle pulse on successful commit
//  div_zero_exc  out  1   1-cycle pulse; control unit enters exception path
//  timeout_exc   out  1   1-cycle pulse; watchdog expired
// BEHAVIOUR
//  Reset (reset = 0, any time, including mid-operation):
//   - state = IDLE, counter = 0, op latch = mult, all outputs 0.
//   - Any in-flight unit result is discarded; HI/LO are untouched.
//  Outputs are registered and are a decode of state plus the op latch.
//  States: IDLE, M_LAUNCH, M_WAIT, D_LAUNCH, D_WAIT, COMMIT, EXC_DZ, EXC_TO.
//  IDLE:
//   - start_mult -> M_LAUNCH; op latch = mult.
//   - start_div with divisor != 0 -> D_LAUNCH; op latch = div.
//   - start_div with divisor == 0 -> EXC_DZ; no launch.
//   - Both starts in the same cycle: mult wins; the div request is dropped.
//  Starts received in any state other than IDLE are ignored.
//  M_LAUNCH / D_LAUNCH:
//   - mult_control / div_control = 1 for exactly this one cycle.
//   - Counter cleared; next state M_WAIT / D_WAIT.
//  M_WAIT / D_WAIT:
//   - Counter increments each cycle; stop flags are sampled only here.
//   - D_WAIT: div_zero takes priority over div_stop and goes to EXC_DZ.
//   - M_WAIT: div_stop, div_zero and start inputs are ignored.
//   - Stop flag seen -> COMMIT.
//   - Counter == MAX_CYCLES-1 with no stop -> EXC_TO.
//   - A stop arriving in that same final cycle wins over the timeout.
//  COMMIT:
//   - HiLo_load = 1, done = 1, sel_mux_hi = sel_mux_lo = op latch; then IDLE.
//  EXC_DZ: div_zero_exc = 1; HiLo_load = 0; then IDLE.
//  EXC_TO: timeout_exc = 1; HiLo_load = 0; then IDLE.
//  sel_mux_hi/lo hold their last committed value outside COMMIT.
//  Latency, with start sampled at edge T:
//   - Launch pulse during cycle T+1; WAIT begins at T+2.
//   - Stop seen at cycle S -> COMMIT at S+1, IDLE at S+2.
//   - Minimum total latency: 3 cycles from start to done.
//   - Zero-divisor short-cut: div_zero_exc at T+1, div_control never asserted.
// STRUCTURE
//  muldiv_pkg: state encoding localparams and HI/LO source codes (SRC_MULT = 0, SRC_DIV = 1).
//  Sub-module cycle_watchdog (CNT_W, MAX_CYCLES):
//   - Inputs clear and enable; output expired.
//   - Instantiated once; the FSM stays in this file.
// TESTING
//  1. start_mult; mult_stop 32 cycles after launch
//     -> one mult_control pulse; HiLo_load + done one cycle later; sel_mux_hi/lo = 0.
//  2. start_div, divisor = 7; div_stop after 10 cycles
//     -> one div_control pulse; commit with sel_mux_hi/lo = 1; busy low 1 cycle after done.
//  3. start_div, divisor = 0
//     -> div_zero_exc at T+1; no div_control, no HiLo_load.
//     In-flight div_zero in D_WAIT together with div_stop -> EXC_DZ.
//  4. start_mult, mult_stop never asserted (MAX_CYCLES = 64)
//     -> timeout_exc exactly 64 cycles after WAIT entry; IDLE next.
//     Repeat with stop on cycle 64 -> COMMIT.
//  5. start_mult and start_div together, then start_div while busy
//     -> only the mult runs; the second request is ignored.
//  6. reset = 0 during D_WAIT
//     -> all outputs 0 immediately; a div_stop after release is ignored; no HiLo_load.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the mult/div sequencer: FSM state encoding and HI/LO source codes.
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_M_LAUNCH = 3'd1,
    ST_M_WAIT   = 3'd2,
    ST_D_LAUNCH = 3'd3,
    ST_D_WAIT   = 3'd4,
    ST_COMMIT   = 3'd5,
    ST_EXC_DZ   = 3'd6,
    ST_EXC_TO   = 3'd7
  } state_e;

  localparam logic SRC_MULT = 1'b0;
  localparam logic SRC_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Bundle between the control unit / arithmetic units (master) and the sequencer (slave).
interface muldiv_sequencer_if;

  logic        start_mult;
  logic        start_div;
  logic [31:0] divisor;
  logic        mult_stop;
  logic        div_stop;
  logic        div_zero;
  logic        mult_control;
  logic        div_control;
  logic        HiLo_load;
  logic        sel_mux_hi;
  logic        sel_mux_lo;
  logic        busy;
  logic        done;
  logic        div_zero_exc;
  logic        timeout_exc;

  modport master (
    output start_mult, start_div, divisor, mult_stop, div_stop, div_zero,
    input  mult_control, div_control, HiLo_load, sel_mux_hi, sel_mux_lo,
           busy, done, div_zero_exc, timeout_exc
  );

  modport slave (
    input  start_mult, start_div, divisor, mult_stop, div_stop, div_zero,
    output mult_control, div_control, HiLo_load, sel_mux_hi, sel_mux_lo,
           busy, done, div_zero_exc, timeout_exc
  );

endinterface

// File: rtl/muldiv_sequencer_cycle_watchdog.sv
// Wait-cycle counter: cleared on launch, counts while enabled, flags the last allowed cycle.
module cycle_watchdog #(
  parameter int CNT_W      = 7,
  parameter int MAX_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/muldiv_sequencer.sv
// Launches the multiplier or divider on request, waits for its stop flag under a watchdog,
// then commits HI/LO or raises a divide-by-zero / timeout exception.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MAX_CYCLES = 64,
  parameter int CNT_W      = 7
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  state_e r_state;
  state_e w_next;
  logic   r_op;
  logic   r_mult_control, r_div_control, r_hilo_load, r_sel_hi, r_sel_lo;
  logic   r_busy, r_done, r_dz_exc, r_to_exc;
  logic   w_wd_clear, w_wd_enable, w_wd_expired;

  assign w_wd_clear  = (r_state == ST_M_LAUNCH) || (r_state == ST_D_LAUNCH);
  assign w_wd_enable = (r_state == ST_M_WAIT)   || (r_state == ST_D_WAIT);

  cycle_watchdog #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_enable),
    .o_expired (w_wd_expired)
  );

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_mult)              w_next = ST_M_LAUNCH;
        else if (bus.start_div)          w_next = (bus.divisor != 32'd0) ? ST_D_LAUNCH : ST_EXC_DZ;
      end
      ST_M_LAUNCH:                       w_next = ST_M_WAIT;
      ST_D_LAUNCH:                       w_next = ST_D_WAIT;
      ST_M_WAIT: begin
        if (bus.mult_stop)               w_next = ST_COMMIT;
        else if (w_wd_expired)           w_next = ST_EXC_TO;
      end
      ST_D_WAIT: begin
        if (bus.div_zero)                w_next = ST_EXC_DZ;
        else if (bus.div_stop)           w_next = ST_COMMIT;
        else if (w_wd_expired)           w_next = ST_EXC_TO;
      end
      default:                           w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_op           <= SRC_MULT;
      r_mult_control <= 1'b0;
      r_div_control  <= 1'b0;
      r_hilo_load    <= 1'b0;
      r_sel_hi       <= SRC_MULT;
      r_sel_lo       <= SRC_MULT;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_dz_exc       <= 1'b0;
      r_to_exc       <= 1'b0;
    end else begin
      r_state        <= w_next;
      if (w_next == ST_M_LAUNCH) r_op <= SRC_MULT;
      if (w_next == ST_D_LAUNCH) r_op <= SRC_DIV;
      r_mult_control <= (w_next == ST_M_LAUNCH);
      r_div_control  <= (w_next == ST_D_LAUNCH);
      r_hilo_load    <= (w_next == ST_COMMIT);
      r_done         <= (w_next == ST_COMMIT);
      r_dz_exc       <= (w_next == ST_EXC_DZ);
      r_to_exc       <= (w_next == ST_EXC_TO);
      r_busy         <= (w_next != ST_IDLE);
      if (w_next == ST_COMMIT) begin
        r_sel_hi <= r_op;
        r_sel_lo <= r_op;
      end
    end
  end

  assign bus.mult_control = r_mult_control;
  assign bus.div_control  = r_div_control;
  assign bus.HiLo_load    = r_hilo_load;
  assign bus.sel_mux_hi   = r_sel_hi;
  assign bus.sel_mux_lo   = r_sel_lo;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.div_zero_exc = r_dz_exc;
  assign bus.timeout_exc  = r_to_exc;

endmodule
